// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default sizes, op encodings
// and the FSM state encoding.
package load_store_unit_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int MEM_LINES_DEF = 128;
    localparam int RD_W          = 3;

    typedef enum logic [1:0] {
        OP_PASS    = 2'b00,
        OP_LOAD    = 2'b01,
        OP_STORE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_LOADWAIT = 2'b01,
        ST_FULL     = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side, writeback-side and data-memory signals of the load/store unit.
// Handshakes: a transfer happens on a clock edge where both valid and ready are 1.
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_LINES = MEM_LINES_DEF
);
    localparam int ADDR_W = $clog2(MEM_LINES);

    logic              exValid;
    logic              exReady;
    logic [1:0]        exOp;
    logic [DATA_W-1:0] exAddr;
    logic [DATA_W-1:0] exData;
    logic [RD_W-1:0]   exRd;

    logic              wbValid;
    logic              wbReady;
    logic [DATA_W-1:0] wbData;
    logic [RD_W-1:0]   wbRd;
    logic              wbWriteEn;
    logic              wbFault;

    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWriteData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] memRdata;

    // master: execute stage, writeback stage and data memory around the unit
    modport master (
        output exValid, exOp, exAddr, exData, exRd, wbReady, memRdata,
        input  exReady, wbValid, wbData, wbRd, wbWriteEn, wbFault,
        input  memAddr, memWriteData, memRead, memWrite
    );

    modport slave (
        input  exValid, exOp, exAddr, exData, exRd, wbReady, memRdata,
        output exReady, wbValid, wbData, wbRd, wbWriteEn, wbFault,
        output memAddr, memWriteData, memRead, memWrite
    );

endinterface

// File: rtl/load_store_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/load_store_unit.sv
// Single-slot load/store unit between execute and writeback; loads take one
// extra cycle for the registered data memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_LINES = MEM_LINES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    lsu,
    output logic [7:0]          faultCount,
    output lsu_state_e          state_dbg_o
);

    localparam int ADDR_W = $clog2(MEM_LINES);
    localparam logic [DATA_W:0] LINES = MEM_LINES[DATA_W:0];

    lsu_state_e        state_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic              wb_we_q;
    logic              wb_fault_q;

    lsu_op_e op;
    logic    in_range;
    logic    accept;
    logic    is_fault;

    assign op       = lsu_op_e'(lsu.exOp);
    assign in_range = {1'b0, lsu.exAddr} < LINES;
    assign is_fault = (op == OP_ILLEGAL) ||
                      (((op == OP_LOAD) || (op == OP_STORE)) && !in_range);

    // Ready is forced low during reset so nothing is accepted while held.
    assign lsu.exReady = !reset && ((state_q == ST_EMPTY) ||
                                    ((state_q == ST_FULL) && lsu.wbReady));
    assign accept      = lsu.exValid && lsu.exReady;

    assign lsu.memAddr      = lsu.exAddr[ADDR_W-1:0];
    assign lsu.memWriteData = lsu.exData;
    assign lsu.memRead      = accept && (op == OP_LOAD)  && in_range;
    assign lsu.memWrite     = accept && (op == OP_STORE) && in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            wb_fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOADWAIT: begin
                    wb_data_q  <= lsu.memRdata;
                    wb_we_q    <= 1'b1;
                    wb_fault_q <= 1'b0;
                    state_q    <= ST_FULL;
                end
                ST_EMPTY, ST_FULL: begin
                    // Accepting from FULL drains the old result in the same edge.
                    if (accept) begin
                        wb_rd_q <= lsu.exRd;
                        if (is_fault) begin
                            wb_data_q  <= '0;
                            wb_we_q    <= 1'b0;
                            wb_fault_q <= 1'b1;
                            state_q    <= ST_FULL;
                        end else if (op == OP_LOAD) begin
                            wb_we_q    <= 1'b0;
                            wb_fault_q <= 1'b0;
                            state_q    <= ST_LOADWAIT;
                        end else begin
                            wb_data_q  <= lsu.exData;
                            wb_we_q    <= (op == OP_PASS);
                            wb_fault_q <= 1'b0;
                            state_q    <= ST_FULL;
                        end
                    end else if ((state_q == ST_FULL) && lsu.wbReady) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign lsu.wbValid   = (state_q == ST_FULL);
    assign lsu.wbData    = wb_data_q;
    assign lsu.wbRd      = wb_rd_q;
    assign lsu.wbWriteEn = wb_we_q;
    assign lsu.wbFault   = wb_fault_q;
    assign state_dbg_o   = state_q;

    sat_counter #(.W(8)) u_fault_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (accept && is_fault),
        .count_o (faultCount)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] fault_count;
    lsu_state_e state_dbg;

    int total = 0;
    int bad   = 0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk         (clk),
        .reset       (reset),
        .lsu         (bus.slave),
        .faultCount  (fault_count),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory (registered read) ----------------
    logic [7:0] env_mem [128];
    initial for (int i = 0; i < 128; i++) env_mem[i] = 8'h00;

    always @(posedge clk) begin
        if (bus.memWrite) env_mem[bus.memAddr] <= bus.memWriteData;
        if (bus.memRead)  bus.memRdata <= env_mem[bus.memAddr];
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [7:0] addr,
                          input logic [7:0] data, input logic [2:0] rd);
        bus.exValid = 1'b1;
        bus.exOp    = op;
        bus.exAddr  = addr;
        bus.exData  = data;
        bus.exRd    = rd;
    endtask

    // ---------------- reference model ----------------
    // Slot contents: kind 0 = data result, 1 = store token, 2 = fault.
    logic [7:0] ref_mem [128];
    initial for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;

    logic       m_slot_v, m_pend;
    int         m_kind;
    logic [7:0] m_data, m_pend_data;
    logic [2:0] m_rd, m_pend_rd;
    int         m_faults;
    logic       m_exp_ready, m_acc, m_in_r;

    initial begin
        m_slot_v = 0; m_pend = 0; m_kind = 0; m_data = 0; m_rd = 0;
        m_pend_data = 0; m_pend_rd = 0; m_faults = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            m_slot_v = 0;
            m_pend   = 0;
            m_faults = 0;
            chk("rst_exready", bus.exReady, 0);
            chk("rst_wbvalid", bus.wbValid, 0);
            chk("rst_faultcount", fault_count, 0);
        end else begin
            m_exp_ready = !m_pend && (!m_slot_v || bus.wbReady);
            chk("exready", bus.exReady, m_exp_ready);
            chk("wbvalid", bus.wbValid, m_slot_v);
            if (m_slot_v) begin
                chk("wb_we", bus.wbWriteEn, m_kind == 0);
                chk("wb_fault", bus.wbFault, m_kind == 2);
                if (m_kind == 0) begin
                    chk("wb_data", bus.wbData, m_data);
                    chk("wb_rd", bus.wbRd, m_rd);
                end
                if (m_kind == 2) chk("wb_fault_data", bus.wbData, 0);
            end
            m_acc  = bus.exValid && m_exp_ready;
            m_in_r = bus.exAddr < 8'd128;
            chk("mem_read", bus.memRead, m_acc && bus.exOp == OP_LOAD && m_in_r);
            chk("mem_write", bus.memWrite, m_acc && bus.exOp == OP_STORE && m_in_r);
            if (bus.memRead || bus.memWrite) chk("mem_addr", bus.memAddr, bus.exAddr[6:0]);
            if (bus.memWrite) chk("mem_wdata", bus.memWriteData, bus.exData);
            chk("faultcount", fault_count, (m_faults > 255) ? 255 : m_faults);

            // advance the model to the state after the coming edge
            if (m_slot_v && bus.wbReady) m_slot_v = 0;
            if (m_pend) begin
                m_slot_v = 1; m_kind = 0; m_data = m_pend_data; m_rd = m_pend_rd; m_pend = 0;
            end
            if (m_acc) begin
                if (bus.exOp == OP_ILLEGAL || (bus.exOp != OP_PASS && !m_in_r)) begin
                    m_slot_v = 1; m_kind = 2; m_faults++;
                end else if (bus.exOp == OP_PASS) begin
                    m_slot_v = 1; m_kind = 0; m_data = bus.exData; m_rd = bus.exRd;
                end else if (bus.exOp == OP_STORE) begin
                    m_slot_v = 1; m_kind = 1;
                    ref_mem[bus.exAddr[6:0]] = bus.exData;
                end else begin
                    m_pend = 1; m_pend_rd = bus.exRd; m_pend_data = ref_mem[bus.exAddr[6:0]];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic acc_prev;
    int   r;

    initial begin
        reset = 1'b1;
        bus.exValid = 0; bus.exOp = 0; bus.exAddr = 0; bus.exData = 0; bus.exRd = 0;
        bus.wbReady = 1'b1;
        #1;
        chk("por_wbvalid", bus.wbValid, 0);
        repeat (2) tick();
        reset = 1'b0;
        #2;
        chk("por_exready", bus.exReady, 1);
        chk("por_state", state_dbg, ST_EMPTY);
        chk("por_faultcount", fault_count, 0);

        // store then load to the same line
        tick();
        set_op(OP_STORE, 8'h05, 8'hA5, 3'd0);
        #2 chk("st_memwrite", bus.memWrite, 1);
        tick();
        set_op(OP_LOAD, 8'h05, 8'h00, 3'd3);
        #2 chk("ld_memread", bus.memRead, 1);
        tick();
        bus.exValid = 0;
        chk("ld_lat1_wbvalid", bus.wbValid, 0);
        tick();
        chk("ld_lat2_wbvalid", bus.wbValid, 1);
        chk("ld_wbdata", bus.wbData, 8'hA5);
        chk("ld_wbrd", bus.wbRd, 3);
        chk("ld_wbwe", bus.wbWriteEn, 1);

        // back-to-back PASS
        for (int i = 0; i < 4; i++) begin
            set_op(OP_PASS, 8'h00, 8'h3C, 3'(i));
            #2 chk("pass_exready", bus.exReady, 1);
            tick();
            chk("pass_wbvalid", bus.wbValid, 1);
            chk("pass_wbdata", bus.wbData, 8'h3C);
            chk("pass_wbrd", bus.wbRd, i);
        end
        bus.exValid = 0;
        tick();

        // out-of-range load, then fault saturation
        set_op(OP_LOAD, 8'h80, 8'h00, 3'd5);
        #2 chk("oor_memread", bus.memRead, 0);
        tick();
        bus.exValid = 0;
        chk("oor_fault", bus.wbFault, 1);
        chk("oor_we", bus.wbWriteEn, 0);
        chk("oor_faultcount", fault_count, 1);
        set_op(OP_ILLEGAL, 8'h00, 8'h00, 3'd0);
        repeat (300) tick();
        bus.exValid = 0;
        chk("sat_faultcount", fault_count, 255);
        tick();

        // load result held under backpressure
        set_op(OP_LOAD, 8'h05, 8'h00, 3'd2);
        tick();
        bus.exValid = 0;
        bus.wbReady = 0;
        tick();
        set_op(OP_STORE, 8'h10, 8'h77, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_exready", bus.exReady, 0);
            chk("bp_memwrite", bus.memWrite, 0);
            chk("bp_memread", bus.memRead, 0);
            chk("bp_wbvalid", bus.wbValid, 1);
            chk("bp_wbdata", bus.wbData, 8'hA5);
            chk("bp_wbrd", bus.wbRd, 2);
            tick();
        end
        bus.exValid = 0;
        bus.wbReady = 1;
        tick();

        // reset while a load is outstanding
        set_op(OP_LOAD, 8'h05, 8'h00, 3'd1);
        tick();
        bus.exValid = 0;
        chk("lw_state", state_dbg, ST_LOADWAIT);
        reset = 1'b1;
        #1;
        chk("arst_wbvalid", bus.wbValid, 0);
        chk("arst_wbrd", bus.wbRd, 0);
        chk("arst_faultcount", fault_count, 0);
        chk("arst_state", state_dbg, ST_EMPTY);
        repeat (2) tick();
        reset = 1'b0;
        #2;
        chk("rel_exready", bus.exReady, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_no_stale", bus.wbValid, 0);
        end

        // random traffic; held ops stay stable until accepted
        acc_prev = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.exValid && !acc_prev)) begin
                bus.exValid = ($urandom_range(0, 9) < 7);
                r = $urandom_range(0, 9);
                bus.exOp = (r < 3) ? OP_PASS : (r < 6) ? OP_LOAD : (r < 9) ? OP_STORE : OP_ILLEGAL;
                r = $urandom_range(0, 9);
                bus.exAddr = (r < 7) ? 8'($urandom_range(0, 15)) :
                             (r < 9) ? 8'($urandom_range(16, 127)) : 8'($urandom_range(128, 255));
                bus.exData = 8'($urandom_range(0, 255));
                bus.exRd   = 3'($urandom_range(0, 7));
            end
            bus.wbReady = ($urandom_range(0, 3) != 0);
            #2;
            acc_prev = bus.exValid && bus.exReady;
            tick();
        end
        bus.exValid = 0;
        bus.wbReady = 1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_W, 8, data and execute-address width.
REQ-002 Parameter MEM_LINES, 128, data memory depth; valid addresses are 0..MEM_LINES-1.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 exValid  input  1  execute stage presents an operation.
REQ-006 exReady  output  1  unit accepts the operation this cycle; combinational.
REQ-007 exOp  input  2  operation: 00 PASS, 01 LOAD, 10 STORE, 11 ILLEGAL.
REQ-008 exAddr  input  8  byte address from the ALU.
REQ-009 exData  input  8  store data, or the PASS result.
REQ-010 exRd  input  3  destination register index.
REQ-011 wbValid  output  1  writeback slot holds a result.
REQ-012 wbReady  input  1  writeback consumes the slot this cycle.
REQ-013 wbData  output  8  result data.
REQ-014 wbRd  output  3  destination register index.
REQ-015 wbWriteEn  output  1  writeback shall write wbData to wbRd.
REQ-016 wbFault  output  1  operation faulted: address out of range or ILLEGAL op.
REQ-017 memAddr  output  7  data memory line number, equal to exAddr[6:0]; combinational.
REQ-018 memWriteData  output  8  data memory write data, equal to exData; combinational.
REQ-019 memRead  output  1  data memory read strobe; combinational.
REQ-020 memWrite  output  1  data memory write strobe; combinational.
REQ-021 memRdata  input  8  data memory registered output, valid 1 cycle after memRead.
REQ-022 faultCount  output  8  saturating count of faulted operations.

Function
REQ-023 Three-state FSM shall be used: EMPTY, LOADWAIT, FULL; accept = exValid & exReady.
REQ-024 exReady shall be 1 in EMPTY, 0 in LOADWAIT, equal to wbReady in FULL, and 0 while reset is high.
REQ-025 inRange shall be exAddr < MEM_LINES; memRead = accept & LOAD & inRange; memWrite = accept & STORE & inRange.
REQ-026 Accepting PASS shall load the slot with {exData, exRd, wbWriteEn=1, wbFault=0} and go to FULL.
REQ-027 Accepting an in-range STORE shall load the slot with {wbWriteEn=0, wbFault=0} as a completion token and go to FULL.
REQ-028 Accepting an in-range LOAD shall latch exRd and go to LOADWAIT; the slot is not yet valid.
REQ-029 In LOADWAIT, the unit shall capture memRdata into wbData with wbWriteEn=1, wbFault=0 and go to FULL on the next edge.
REQ-030 Load latency shall be wbValid high 2 edges after the accept cycle; PASS/STORE latency shall be 1 edge.
REQ-031 Accepting an out-of-range LOAD/STORE or an ILLEGAL op shall assert no memory strobe, load the slot with {wbData=0, wbWriteEn=0, wbFault=1}, and go to FULL.
REQ-032 In FULL with wbReady=0, all wb* outputs shall stay stable; with wbReady=1 and no accept, the unit shall go to EMPTY.
REQ-033 In FULL, wbReady=1 together with accept shall drain and refill in the same edge, giving PASS/STORE throughput of 1 per cycle and LOAD throughput of 1 per 2 cycles.
REQ-034 wbValid shall be 1 exactly in FULL.
REQ-035 faultCount shall increment on each faulted accept and saturate at 255.
REQ-036 A STORE followed by a LOAD to the same line in the next accepted cycle shall return the stored value.

Reset
REQ-037 Reset assertion shall immediately force: state EMPTY; wbValid, wbData, wbRd, wbWriteEn, wbFault and faultCount to 0.
REQ-038 Reset during LOADWAIT shall discard the pending load; no result shall be produced after reset is released.

Structure
REQ-039 A shared package shall hold the op encodings, FSM state encoding, DATA_W and MEM_LINES defaults.
REQ-040 The faultCount saturating counter shall be one sub-module, sat_counter; everything else stays flat.

Verification
REQ-041 STORE addr 0x05 data 0xA5, then LOAD addr 0x05 rd 3 -> memWrite 1 cycle, then wbValid 2 edges after the load accept with wbData 0xA5, wbRd 3, wbWriteEn 1.
REQ-042 PASS data 0x3C on 4 consecutive cycles with wbReady=1 -> 4 results on 4 consecutive cycles, exReady never low.
REQ-043 LOAD addr 0x80 -> no memRead; wbFault 1, wbWriteEn 0; faultCount 0 -> 1; 300 faults -> faultCount holds 255.
REQ-044 Hold wbReady=0 for 5 cycles while a LOAD result sits in the slot -> wb* outputs stable, exReady 0, no memory strobes.
REQ-045 Assert reset during LOADWAIT -> wbValid 0 immediately; after release, the unit is EMPTY with exReady 1 and no stale result appears.
